// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg
// Shared definitions for the two-to-one SRAM-like bus arbiter:
//   - SRAM-like field widths
//   - owner tags stored in the outstanding-transaction FIFO
//   - arbitration FSM encodings and the grant selector type
package sram_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;

  // Which requester issued an outstanding transaction.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_t;

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// owner_fifo
// DEPTH x 1-bit FIFO remembering which requester owns each accepted,
// not-yet-answered memory transaction (responses come back in order).
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push, din     enqueue an owner tag (ignored when full)
//   pop           dequeue the head (ignored when empty)
//   head          owner tag of the oldest outstanding transaction
//   full, empty   occupancy flags
module owner_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots  <= {DEPTH{OWNER_INST}};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares one SRAM-like memory port between the instruction-fetch and the
// data requester. Address phases are serialized; each accepted request is
// tagged with its owner in an in-order FIFO so that responses are routed
// back to the requester that issued them.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   inst_* / data_*            requester side (req, wr, size, wstrb, addr,
//                              wdata in; addr_ok, data_ok, rdata out)
//   mem_*                      memory side (muxed request out; addr_ok,
//                              data_ok, rdata in)
//   err                        sticky: response arrived with nothing pending
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  grant_t              grant;
  logic                grant_req;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_max;
  logic                accept;
  logic                fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                resp_valid;

  assign starve_max = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Grant selection: a pending address phase locks the mux to its owner;
  // otherwise data has priority unless inst has waited out its starvation
  // budget.
  always_comb begin
    grant = GNT_NONE;
    case (state)
      ARB_HOLD_I: grant = GNT_INST;
      ARB_HOLD_D: grant = GNT_DATA;
      default: begin
        if (data_req && !(inst_req && starve_max)) begin
          grant = GNT_DATA;
        end else if (inst_req) begin
          grant = GNT_INST;
        end
      end
    endcase
  end

  // Request field mux; fields read as zero when nobody holds the grant.
  always_comb begin
    grant_req = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_INST: begin
        grant_req = inst_req;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
      GNT_DATA: begin
        grant_req = data_req;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  // A full owner FIFO blocks new address phases; reset silences the port.
  assign mem_req      = grant_req && !fifo_full && !reset;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (grant == GNT_INST);
  assign data_addr_ok = accept && (grant == GNT_DATA);

  // A response with nothing outstanding is dropped and flagged instead.
  assign resp_valid   = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = resp_valid && (fifo_head == OWNER_INST);
  assign data_data_ok = resp_valid && (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  owner_fifo #(
    .DEPTH(DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (mem_data_ok),
    .din   ((grant == GNT_DATA) ? OWNER_DATA : OWNER_INST),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration FSM: an offered but unaccepted request locks the grant;
  // acceptance releases it. With mem_req low (idle or FIFO full) the state
  // is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else if (mem_req) begin
      if (mem_addr_ok) begin
        state <= ARB_IDLE;
      end else if (grant == GNT_DATA) begin
        state <= ARB_HOLD_D;
      end else begin
        state <= ARB_HOLD_I;
      end
    end
  end

  // Starvation counter: consecutive data acceptances while inst waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (data_addr_ok && !starve_max) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky protocol error: response with an empty owner FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
// Directed scenarios followed by a randomized phase, all checked every
// cycle against a transaction-level reference model (owner queue, lock,
// data streak, sticky error).
module tb_sram_bus_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err;

  sram_bus_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model: who owns each outstanding transaction, who (if anyone)
  // holds an unaccepted address phase (0 none, 1 inst, 2 data), how many
  // data acceptances happened in a row while inst waited, sticky error.
  bit ownerQ[$];
  int lockOwner;
  int dataStreak;
  bit errModel;

  int          expGrant;
  bit          expMemReq, expInstAcc, expDataAcc, expInstResp, expDataResp;
  logic [31:0] expAddr, expWdata;
  logic [6:0]  expCtl;
  bit          instAccepted, dataAccepted;

  logic        sMemReq, sInstAddrOk, sDataAddrOk, sInstDataOk, sDataDataOk, sErr;
  logic [31:0] sMemAddr, sInstRdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    ownerQ.delete();
    lockOwner    = 0;
    dataStreak   = 0;
    errModel     = 1'b0;
    instAccepted = 1'b0;
    dataAccepted = 1'b0;
  endfunction

  function automatic void predict();
    bit gReq;
    if (lockOwner != 0) expGrant = lockOwner;
    else if (data_req && !(inst_req && dataStreak == STARVE_LIMIT)) expGrant = 2;
    else if (inst_req) expGrant = 1;
    else expGrant = 0;
    gReq = (expGrant == 1) ? inst_req : (expGrant == 2) ? data_req : 1'b0;
    expMemReq  = gReq && (ownerQ.size() < DEPTH);
    expInstAcc = expMemReq && mem_addr_ok && (expGrant == 1);
    expDataAcc = expMemReq && mem_addr_ok && (expGrant == 2);
    expInstResp = 1'b0;
    expDataResp = 1'b0;
    if (mem_data_ok && ownerQ.size() > 0) begin
      expInstResp = (ownerQ[0] == 1'b0);
      expDataResp = (ownerQ[0] == 1'b1);
    end
    if (expGrant == 1) begin
      expAddr = inst_addr; expWdata = inst_wdata;
      expCtl  = {inst_wr, inst_size, inst_wstrb};
    end else if (expGrant == 2) begin
      expAddr = data_addr; expWdata = data_wdata;
      expCtl  = {data_wr, data_size, data_wstrb};
    end else begin
      expAddr = '0; expWdata = '0; expCtl = '0;
    end
  endfunction

  task automatic checkCycle();
    predict();
    sMemReq = mem_req; sInstAddrOk = inst_addr_ok; sDataAddrOk = data_addr_ok;
    sInstDataOk = inst_data_ok; sDataDataOk = data_data_ok; sErr = err;
    sMemAddr = mem_addr; sInstRdata = inst_rdata;
    checkOutput("mem_req", 32'(mem_req), 32'(expMemReq));
    checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(expInstAcc));
    checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(expDataAcc));
    checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(expInstResp));
    checkOutput("data_data_ok", 32'(data_data_ok), 32'(expDataResp));
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wdata", mem_wdata, expWdata);
    checkOutput("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'(expCtl));
    checkOutput("inst_rdata", inst_rdata, mem_rdata);
    checkOutput("data_rdata", data_rdata, mem_rdata);
    checkOutput("err", 32'(err), 32'(errModel));
  endtask

  function automatic void updateModel();
    if (mem_data_ok) begin
      if (ownerQ.size() == 0) errModel = 1'b1;
      else void'(ownerQ.pop_front());
    end
    if (expInstAcc) ownerQ.push_back(1'b0);
    if (expDataAcc) ownerQ.push_back(1'b1);
    if (expMemReq) lockOwner = mem_addr_ok ? 0 : expGrant;
    if (!inst_req || expInstAcc) dataStreak = 0;
    else if (expDataAcc && dataStreak < STARVE_LIMIT) dataStreak++;
    instAccepted = expInstAcc;
    dataAccepted = expDataAcc;
  endfunction

  // Caller drives inputs just after a falling edge, then calls this.
  task automatic runCycle();
    #1;
    checkCycle();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic setIdle();
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic setInst(input logic [31:0] addr);
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
    inst_wstrb = 4'hf; inst_addr = addr; inst_wdata = 32'h0;
  endtask

  task automatic setData(input logic [31:0] addr, input logic wr);
    data_req = 1'b1; data_wr = wr; data_size = 2'd2;
    data_wstrb = 4'hf; data_addr = addr; data_wdata = 32'hA5A50000 ^ addr;
  endtask

  task automatic drain();
    setIdle();
    for (int i = 0; i < 3 * DEPTH && ownerQ.size() > 0; i++) begin
      mem_data_ok = 1'b1;
      runCycle();
    end
    mem_data_ok = 1'b0;
  endtask

  // Random requesters that honour the hold-until-accepted rule.
  task automatic applyStimulus();
    if (!inst_req || instAccepted) begin
      inst_req   = ($urandom_range(0, 9) < 6);
      inst_wr    = 1'($urandom_range(0, 1));
      inst_size  = 2'($urandom_range(0, 2));
      inst_wstrb = 4'($urandom);
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end
    if (!data_req || dataAccepted) begin
      data_req   = ($urandom_range(0, 9) < 6);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    mem_addr_ok = ($urandom_range(0, 9) < 6);
    mem_data_ok = (ownerQ.size() > 0) ? 1'($urandom_range(0, 1))
                                      : ($urandom_range(0, 49) == 0);
    mem_rdata   = $urandom;
  endtask

  logic [1:0] starvePattern [10];

  initial begin
    // Reset with everything active: handshakes must stay low.
    reset = 1'b1;
    setInst(32'h1000); setData(32'h2000, 1'b1);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("rst mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    checkOutput("rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    setIdle();
    runCycle();

    $display("[TB] single inst fetch");
    setInst(32'h1C000000); mem_addr_ok = 1'b1;
    runCycle();
    checkOutput("t1 inst_addr_ok", 32'(sInstAddrOk), 32'd1);
    checkOutput("t1 mem_addr", sMemAddr, 32'h1C000000);
    setIdle();
    runCycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h02800000;
    runCycle();
    checkOutput("t1 inst_data_ok", 32'(sInstDataOk), 32'd1);
    checkOutput("t1 inst_rdata", sInstRdata, 32'h02800000);
    checkOutput("t1 data_data_ok", 32'(sDataDataOk), 32'd0);
    setIdle();
    runCycle();

    $display("[TB] starvation pattern");
    starvePattern = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    setInst(32'h1C000100); setData(32'h00080000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_addr_ok = 1'b1;
      mem_data_ok = (ownerQ.size() > 0);
      runCycle();
      checkOutput($sformatf("t2 grant%0d", i), 32'({sInstAddrOk, sDataAddrOk}),
                  32'(starvePattern[i]));
    end
    drain();

    $display("[TB] hold on data");
    setData(32'h00090000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) setInst(32'h1C000200);
      runCycle();
      checkOutput($sformatf("t3 mem_addr%0d", i), sMemAddr, 32'h00090000);
    end
    mem_addr_ok = 1'b1;
    runCycle();
    checkOutput("t3 data_addr_ok", 32'({sInstAddrOk, sDataAddrOk}), 32'b01);
    data_req = 1'b0;
    runCycle();
    checkOutput("t3 inst after", 32'(sInstAddrOk), 32'd1);
    drain();

    $display("[TB] fifo full");
    setInst(32'h1C000300); mem_addr_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput($sformatf("t4 mem_req%0d", i), 32'(sMemReq), (i < 4) ? 32'd1 : 32'd0);
    end
    mem_data_ok = 1'b1;
    runCycle();
    checkOutput("t4 pop no unblock", 32'(sMemReq), 32'd0);
    mem_data_ok = 1'b0;
    runCycle();
    checkOutput("t4 resume", 32'(sInstAddrOk), 32'd1);
    drain();

    $display("[TB] interleaved responses");
    setIdle(); setInst(32'h1C000400); mem_addr_ok = 1'b1;
    runCycle();
    setIdle(); setData(32'h000A0000, 1'b0); mem_addr_ok = 1'b1;
    runCycle();
    setIdle(); setInst(32'h1C000404); mem_addr_ok = 1'b1;
    runCycle();
    setIdle();
    for (int i = 0; i < 3; i++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'h100 + 32'(i);
      runCycle();
      checkOutput($sformatf("t5 resp%0d", i), 32'({sInstDataOk, sDataDataOk}),
                  (i == 1) ? 32'b01 : 32'b10);
    end
    setIdle();

    $display("[TB] error and mid-burst reset");
    mem_data_ok = 1'b1;
    runCycle();
    mem_data_ok = 1'b0;
    runCycle();
    checkOutput("t6 err set", 32'(sErr), 32'd1);
    runCycle();
    checkOutput("t6 err sticky", 32'(sErr), 32'd1);
    setInst(32'h1C000500); setData(32'h000B0000, 1'b1); mem_addr_ok = 1'b1;
    runCycle();
    runCycle();
    mem_data_ok = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("t6 rst mem_req", 32'(mem_req), 32'd0);
    checkOutput("t6 rst addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    checkOutput("t6 rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    checkOutput("t6 rst err", 32'(err), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    setIdle();
    runCycle();
    mem_data_ok = 1'b1;
    runCycle();
    setIdle();
    runCycle();
    checkOutput("t6 fifo empty after rst", 32'(sErr), 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus();
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
